// File: rtl/spi_coeff_bridge.sv
// spi_coeff_bridge: oversampled SPI mode-0 slave decoding 24-bit frames into coefficient read/write strobes
module spi_coeff_bridge #(
  parameter int RD_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] coeff_read_out,
  output logic       msg_in,
  output logic       coeff_rw,
  output logic [9:0] coeff_addr,
  output logic [7:0] coeff_in,
  output logic       frame_err,
  output logic       busy
);
  localparam int FRAME_BITS = 24;
  typedef enum logic [2:0] {WAIT_HI, IDLE, RX, RD_WAIT, WR, DRAIN} state_t;
  state_t      state_q, state_d;
  logic [2:0]  sclk_q;
  logic [1:0]  cs_q, mosi_q;
  logic [4:0]  cnt_q, cnt_d;
  logic [23:0] sr_q, sr_d;
  logic [7:0]  tx_q, tx_d;
  logic [3:0]  lat_q, lat_d;
  logic        rd_q, rd_d;
  logic        miso_q, miso_d, msg_q, msg_d, rw_q, rw_d, err_q, err_d;
  logic [9:0]  addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic        cs_s, rise, fall, active;
  assign cs_s   = cs_q[1];
  assign rise   = sclk_q[1] & ~sclk_q[2];
  assign fall   = ~sclk_q[1] & sclk_q[2];
  assign active = state_q == RX || state_q == RD_WAIT;
  // Pin synchronizers; cleared on reset so a frame in flight keeps the FSM parked in WAIT_HI
  always_ff @(posedge clk)
    if (rst) begin
      sclk_q <= '0;
      cs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_q   <= {cs_q[0], cs_n};
      mosi_q <= {mosi_q[0], mosi};
    end
  // State and output registers
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= WAIT_HI;
      cnt_q   <= '0;
      sr_q    <= '0;
      tx_q    <= '0;
      lat_q   <= '0;
      rd_q    <= 1'b0;
      miso_q  <= 1'b0;
      msg_q   <= 1'b0;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      tx_q    <= tx_d;
      lat_q   <= lat_d;
      rd_q    <= rd_d;
      miso_q  <= miso_d;
      msg_q   <= msg_d;
      rw_q    <= rw_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  // Bit capture, miso shifting and frame sequencing; a raised cs_n always beats a coincident sclk edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    tx_d    = tx_q;
    lat_d   = lat_q;
    rd_d    = rd_q;
    miso_d  = miso_q;
    msg_d   = 1'b0;
    rw_d    = rw_q;
    err_d   = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    if (active && !cs_s && rise && cnt_q != 5'(FRAME_BITS)) begin
      sr_d  = {sr_q[22:0], mosi_q[1]};
      cnt_d = cnt_q + 5'd1;
    end
    if (cs_s || state_q == WAIT_HI || state_q == IDLE) miso_d = 1'b0;
    else if (fall) miso_d = cnt_q[4:3] == 2'b10 ? tx_q[~cnt_q[2:0]] : 1'b0;
    case (state_q)
      WAIT_HI: if (cs_s) state_d = IDLE;
      IDLE: if (!cs_s) begin
        state_d = RX;
        cnt_d   = '0;
        sr_d    = '0;
        tx_d    = '0;
        rd_d    = 1'b0;
      end
      RX: if (cs_s) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else if (cnt_q == 5'd14 && !sr_q[13] && !rd_q) begin
        state_d = RD_WAIT;
        lat_d   = '0;
        rd_d    = 1'b1;
      end else if (cnt_q == 5'(FRAME_BITS)) state_d = sr_q[23] ? WR : DRAIN;
      RD_WAIT: if (cs_s) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        lat_d = lat_q + 4'd1;
        if (lat_q == 4'd0) begin
          msg_d  = 1'b1;
          rw_d   = 1'b0;
          addr_d = sr_q[9:0];
        end
        if (lat_q == 4'(RD_LAT + 1)) begin
          tx_d    = coeff_read_out;
          state_d = RX;
        end
      end
      WR: begin
        msg_d   = 1'b1;
        rw_d    = 1'b1;
        addr_d  = sr_q[19:10];
        din_d   = sr_q[7:0];
        state_d = DRAIN;
      end
      DRAIN: if (cs_s) state_d = IDLE;
      default: state_d = WAIT_HI;
    endcase
  end
  assign miso       = miso_q;
  assign msg_in     = msg_q;
  assign coeff_rw   = rw_q;
  assign coeff_addr = addr_q;
  assign coeff_in   = din_q;
  assign frame_err  = err_q;
  assign busy       = state_q != WAIT_HI && !cs_s;
endmodule

// File: tb/tb_spi_coeff_bridge.sv
// tb_spi_coeff_bridge: randomized SPI master with a scoreboard of expected coefficient commands
module tb_spi_coeff_bridge;
  localparam int RD_LAT = 2;
  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic miso, msg_in, coeff_rw, frame_err, busy;
  logic [9:0] coeff_addr;
  logic [7:0] coeff_in, coeff_read_out;
  int n_chk = 0, n_pass = 0, cyc = 0, last_rise = 0;
  logic [7:0] ref_mem [1024];
  logic [7:0] pipe [RD_LAT];
  typedef struct {int kind; logic [9:0] addr; logic [7:0] data;} exp_t;
  exp_t exp_q[$];
  exp_t m;

  spi_coeff_bridge #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .coeff_read_out(coeff_read_out), .msg_in(msg_in), .coeff_rw(coeff_rw),
    .coeff_addr(coeff_addr), .coeff_in(coeff_in), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // datapath responder: read data appears RD_LAT cycles after the read strobe, noise otherwise
  always @(posedge clk) begin
    pipe[0] <= (msg_in && !coeff_rw) ? ref_mem[coeff_addr] : 8'($urandom);
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign coeff_read_out = pipe[RD_LAT-1];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // monitor: every strobe or error pulse is matched against the oldest expectation
  always @(negedge clk)
    if (!rst && (msg_in || frame_err)) begin
      if (exp_q.size() == 0) chk("unexpected_cmd", {msg_in, frame_err}, 0);
      else begin
        m = exp_q.pop_front();
        chk("cmd_kind", {msg_in, frame_err}, m.kind == 2 ? 2'b01 : 2'b10);
        if (m.kind != 2) begin
          chk("cmd_rw", coeff_rw, m.kind == 1 ? 1 : 0);
          chk("cmd_addr", coeff_addr, m.addr);
        end
        if (m.kind == 1) begin
          chk("wr_data", coeff_in, m.data);
          chk("wr_latency", cyc - last_rise, 5);
        end
      end
    end

  function automatic logic [23:0] word(input logic rw, input int addr, input logic [7:0] d);
    return {rw, 3'($urandom), 10'(addr), 2'($urandom), d};
  endfunction

  task automatic frame(input logic [23:0] w, input int nbits, input int half, input int gap, input int rst_at);
    logic [7:0] tx;
    bit rd;
    exp_t e;
    rd = !w[23] && nbits >= 14 && rst_at < 0;
    tx = rd ? ref_mem[w[19:10]] : 8'h00;
    if (rst_at < 0) begin
      if (rd) begin
        e = '{0, w[19:10], 8'h00};
        exp_q.push_back(e);
      end
      if (w[23] && nbits >= 24) begin
        e = '{1, w[19:10], w[7:0]};
        exp_q.push_back(e);
        ref_mem[w[19:10]] = w[7:0];
      end
      if (nbits < 24) begin
        e = '{2, 10'h0, 8'h00};
        exp_q.push_back(e);
      end
    end
    cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = i < 24 ? w[23-i] : 1'($urandom);
      if (i == rst_at) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_outs", {miso, msg_in, coeff_rw, coeff_addr, coeff_in, frame_err, busy}, 0);
      end
      repeat (half) @(negedge clk);
      if (i == 0 && rst_at < 0) chk("busy_in_frame", busy, 1);
      if (rst_at < 0) chk($sformatf("miso_bit%0d", i), miso, (i >= 16 && i < 24) ? tx[3'(23-i)] : 1'b0);
      sclk = 1'b1;
      if (i == 23) last_rise = cyc;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (half) @(negedge clk);
    cs_n = 1'b1;
    repeat (gap) @(negedge clk);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) ref_mem[a] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("reset_outs", {miso, msg_in, coeff_rw, coeff_addr, coeff_in, frame_err, busy}, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    ref_mem[260] = 8'hC3;
    frame(word(1'b1, 130, 8'h5A), 24, 4, 6, -1);
    frame(word(1'b0, 260, 8'h00), 24, 4, 6, -1);
    frame(word(1'b1, 140, 8'h99), 20, 4, 6, -1);
    frame(word(1'b1, 300, 8'hA7), 24, 5, 6, -1);
    frame(word(1'b1, 150, 8'h3C), 28, 4, 6, -1);
    frame(word(1'b1, 190, 8'h77), 24, 4, 6, 10);
    frame(word(1'b0, 130, 8'h00), 24, 4, 6, -1);
    frame(word(1'b1, 128, 8'h11), 24, 4, 4, -1);
    frame(word(1'b0, 198, 8'h00), 24, 4, 4, -1);
    frame(word(1'b1, 326, 8'hFF), 24, 4, 4, -1);
    frame(word(1'b0, 128, 8'h00), 24, 4, 4, -1);
    for (int k = 0; k < 20; k++) begin
      logic rw;
      int addr, n;
      rw = 1'($urandom);
      addr = $urandom_range(0, 1) ? int'($urandom_range(128, 198)) : int'($urandom_range(256, 326));
      case ($urandom_range(0, 3))
        0: n = $urandom_range(5, 12);
        1: n = $urandom_range(18, 23);
        2: n = $urandom_range(25, 28);
        default: n = 24;
      endcase
      frame(word(rw, addr, 8'($urandom)), n, $urandom_range(4, 7), $urandom_range(4, 8), -1);
    end
    repeat (20) @(negedge clk);
    chk("pending_cmds", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
